// File: rtl/sixteen_segment_pkg.sv
// Shared definitions for the sixteen-segment scan scheduler.
//   SEG_SLOTS    : segment slots per digit (16 segments + decimal point)
//   scan_state_t : scan FSM encoding
//   char_t       : one character-store entry (blank flag, decimal point, glyph)
//   FONT_TABLE   : active-low glyph patterns, bit15 = a ... bit0 = r
package sixteen_segment_pkg;

  localparam int SEG_SLOTS = 17;

  typedef enum logic [1:0] {
    HOLD       = 2'd0,
    SCAN_BLANK = 2'd1,
    SCAN_DRIVE = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] glyph;
  } char_t;

  localparam char_t BLANK_CHAR = '{blank: 1'b1, dp: 1'b0, glyph: 4'h0};

  // Segment order within a pattern: a,b,c,d,e,f,g,h,k,m,n,u,p,t,s,r (bit15 .. bit0).
  // A 0 bit lights the segment.
  localparam logic [15:0] FONT_TABLE [16] = '{
    16'h00FF,  // 0
    16'hCFFF,  // 1
    16'h11E7,  // 2
    16'h03E7,  // 3
    16'hCEE7,  // 4
    16'h22E7,  // 5
    16'h20E7,  // 6
    16'h0FFF,  // 7
    16'h00E7,  // 8
    16'h02E7,  // 9
    16'h0CE7,  // A
    16'h03B5,  // B
    16'h30FF,  // C
    16'h03BD,  // D
    16'h30E7,  // E
    16'h3CEF   // F
  };

endpackage

// File: rtl/sixteen_segment_font.sv
// Glyph decoder: maps a hex glyph code to its active-low 16-segment pattern.
//   glyph   in  4   hex glyph code 0..F
//   pattern out 16  active-low segments, bit15 = a ... bit0 = r
module sixteen_segment_font
  import sixteen_segment_pkg::*;
(
  input  logic [3:0]  glyph,
  output logic [15:0] pattern
);

  assign pattern = FONT_TABLE[glyph];

endmodule

// File: rtl/sixteen_segment_scan_scheduler.sv
// Scan scheduler for a multi-digit common-anode 16-segment display. A
// double-buffered character store feeds a scanner that lights one segment of
// one digit at a time, so the shared current-limit resistor always carries
// a single segment's current.
//
// Optional feature macro: SIXTEEN_SEGMENT_PWM_EN adds a brightness[3:0] input
// that shortens the lit part of every drive phase.
//
// Ports:
//   CLK            in   1           system clock, posedge
//   reset          in   1           synchronous, active-high
//   enable         in   1           1 = scan, 0 = dark and parked at frame start
//   brightness     in   4           (PWM build only) lit fraction in 1/16ths
//   wr_valid       in   1           host write request
//   wr_ready       out  1           shadow buffer accepts a write
//   wr_addr        in   DW          digit index
//   wr_char        in   4           hex glyph code
//   wr_dp          in   1           decimal point lit
//   wr_blank       in   1           digit fully dark
//   commit         in   1           request shadow->active swap at next frame start
//   commit_pending out  1           swap requested, not yet performed
//   frame_start    out  1           pulse on the first cycle of digit 0 slot 0
//   segment_n      out  17          active-low cathodes {a..r,dp}, bit16 = a
//   digit_en       out  NUM_DIGITS  active-high anode enables, at most one set
module sixteen_segment_scan_scheduler
  import sixteen_segment_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int DWELL_CYCLES = 4096,
  parameter  int BLANK_CYCLES = 256,
  localparam int DW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  enable,
`ifdef SIXTEEN_SEGMENT_PWM_EN
  input  logic [3:0]            brightness,
`endif
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DW-1:0]         wr_addr,
  input  logic [3:0]            wr_char,
  input  logic                  wr_dp,
  input  logic                  wr_blank,
  input  logic                  commit,
  output logic                  commit_pending,
  output logic                  frame_start,
  output logic [16:0]           segment_n,
  output logic [NUM_DIGITS-1:0] digit_en
);

  localparam int          CW           = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int          DRIVE_CYCLES = DWELL_CYCLES - BLANK_CYCLES;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [4:0]  SLOT_LAST    = 5'(SEG_SLOTS - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  // Each slot opens in the blank phase unless there is no blank phase at all.
  localparam scan_state_t SLOT_ENTRY   = (BLANK_CYCLES > 0) ? SCAN_BLANK : SCAN_DRIVE;

  scan_state_t   state;
  logic [CW-1:0] dwell;
  logic [4:0]    slot;
  logic [DW-1:0] digit;

  char_t shadow_buf [NUM_DIGITS];
  char_t active_buf [NUM_DIGITS];

  logic                  frame_first;
  logic                  do_swap;
  logic                  wr_fire;
  logic                  pwm_on;
  logic                  lit;
  char_t                 cur;
  logic [15:0]           glyph_pattern;
  logic [16:0]           seg_next;
  logic [NUM_DIGITS-1:0] digit_onehot;

  assign wr_ready = ~commit_pending;
  assign wr_fire  = wr_valid && wr_ready;

  // Counter state sitting on digit 0 / slot 0 / cycle 0 while scanning: the
  // swap and the frame_start pulse both land on the edge that leaves it.
  assign frame_first = enable && (state != HOLD) && (dwell == '0) &&
                       (slot == '0) && (digit == '0);
  assign do_swap     = frame_first && commit_pending;

  // The buffer being swapped in is already what this frame shows, even on
  // the edge that performs the swap.
  assign cur = do_swap ? shadow_buf[digit] : active_buf[digit];

  sixteen_segment_font u_font (
    .glyph   (cur.glyph),
    .pattern (glyph_pattern)
  );

`ifdef SIXTEEN_SEGMENT_PWM_EN
  logic [CW-1:0] drive_offset;
  assign drive_offset = dwell - CW'(BLANK_CYCLES);
  assign pwm_on = int'(drive_offset) < (int'({28'd0, brightness}) * DRIVE_CYCLES) / 16;
`else
  assign pwm_on = 1'b1;
`endif

  assign lit          = enable && (state == SCAN_DRIVE) && !cur.blank && pwm_on;
  assign digit_onehot = NUM_DIGITS'(1) << digit;

  always_comb begin
    // NOTE: default every output of the block first so no path leaves it
    // unassigned and infers a latch.
    seg_next = '1;
    if (slot == SLOT_LAST) begin
      seg_next[0] = ~cur.dp;
    end else begin
      seg_next[5'd16 - slot] = glyph_pattern[4'(5'd15 - slot)];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state          <= HOLD;
      dwell          <= '0;
      slot           <= '0;
      digit          <= '0;
      commit_pending <= 1'b0;
      frame_start    <= 1'b0;
      segment_n      <= '1;
      digit_en       <= '0;
      // NOTE: the character store is a handful of flops that must read as
      // blank after reset, so it is reset explicitly rather than inferred as RAM.
      for (int d = 0; d < NUM_DIGITS; d++) begin
        shadow_buf[d] <= BLANK_CHAR;
        active_buf[d] <= BLANK_CHAR;
      end
    end else begin
      // Out-of-range addresses match no entry and are dropped.
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (wr_fire && (wr_addr == DW'(d))) begin
          shadow_buf[d] <= '{blank: wr_blank, dp: wr_dp, glyph: wr_char};
        end
      end

      if (do_swap) begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
          active_buf[d] <= shadow_buf[d];
        end
        commit_pending <= 1'b0;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end

      frame_start <= frame_first;
      segment_n   <= lit ? seg_next : '1;
      digit_en    <= lit ? digit_onehot : '0;

      if (!enable) begin
        state <= HOLD;
        dwell <= '0;
        slot  <= '0;
        digit <= '0;
      end else begin
        case (state)
          HOLD: state <= SLOT_ENTRY;
          SCAN_BLANK, SCAN_DRIVE: begin
            if (dwell == DWELL_LAST) begin
              dwell <= '0;
              state <= SLOT_ENTRY;
              if (slot == SLOT_LAST) begin
                slot  <= '0;
                digit <= (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
              end else begin
                slot <= slot + 1'b1;
              end
            end else begin
              dwell <= dwell + 1'b1;
              if ((state == SCAN_BLANK) && (dwell == BLANK_LAST)) begin
                state <= SCAN_DRIVE;
              end
            end
          end
          default: state <= HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sixteen_segment_scan_scheduler.sv
// Self-checking bench for sixteen_segment_scan_scheduler with two digits,
// eight-cycle slots and two blank cycles per slot. A position-based display
// model checks every output on every cycle; each scenario task adds directed
// checks against hand-computed values.
module tb_sixteen_segment_scan_scheduler;

  localparam int ND    = 2;
  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int SLOTS = 17;
  localparam int FRAME = ND * SLOTS * DWELL;  // 272
`ifdef SIXTEEN_SEGMENT_PWM_EN
  localparam int LIT_PER_SLOT = 5;           // brightness 15: 15*6/16
`else
  localparam int LIT_PER_SLOT = 6;
`endif

  logic        CLK = 1'b0;
  logic        reset;
  logic        enable;
  logic        wr_valid;
  logic        wr_ready;
  logic [0:0]  wr_addr;
  logic [3:0]  wr_char;
  logic        wr_dp;
  logic        wr_blank;
  logic        commit;
  logic        commit_pending;
  logic        frame_start;
  logic [16:0] segment_n;
  logic [1:0]  digit_en;
`ifdef SIXTEEN_SEGMENT_PWM_EN
  logic [3:0]  brightness;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sixteen_segment_scan_scheduler #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .enable         (enable),
`ifdef SIXTEEN_SEGMENT_PWM_EN
    .brightness     (brightness),
`endif
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_char        (wr_char),
    .wr_dp          (wr_dp),
    .wr_blank       (wr_blank),
    .commit         (commit),
    .commit_pending (commit_pending),
    .frame_start    (frame_start),
    .segment_n      (segment_n),
    .digit_en       (digit_en)
  );

  // ---------------- display model ----------------
  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] glyph;
  } m_char_t;

  m_char_t m_active [ND];
  m_char_t m_shadow [ND];
  logic    m_pending;
  int      m_pos;  // -2 parked, -1 entry cycle, >=0 position within the scan

  function automatic logic [15:0] exp_font(input logic [3:0] g);
    case (g)
      4'h0:    return 16'h00FF;
      4'h1:    return 16'hCFFF;
      4'h2:    return 16'h11E7;
      4'h8:    return 16'h00E7;
      4'hA:    return 16'h0CE7;
      4'hF:    return 16'h3CEF;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_active[d] = '{blank: 1'b1, dp: 1'b0, glyph: 4'h0};
      m_shadow[d] = '{blank: 1'b1, dp: 1'b0, glyph: 4'h0};
    end
    m_pending = 1'b0;
    m_pos     = -2;
  endtask

  // Clock n cycles, update the model for what the edge captured, compare all outputs.
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      logic        fire;
      logic        e_fs;
      logic [16:0] e_seg;
      logic [1:0]  e_en;
      logic [15:0] pat;
      int          dw;
      int          sl;
      int          dg;
      logic        pwm_ok;
      fire = wr_valid && !m_pending;
      e_fs = 1'b0;
      @(posedge CLK);
      #1;
      if (reset) begin
        model_reset();
      end else begin
        if (fire) m_shadow[wr_addr] = '{blank: wr_blank, dp: wr_dp, glyph: wr_char};
        if (!enable)           m_pos = -2;
        else if (m_pos == -2)  m_pos = -1;
        else                   m_pos = m_pos + 1;
        e_fs = (m_pos >= 0) && ((m_pos % FRAME) == 0);
        if (e_fs && m_pending) begin
          for (int d = 0; d < ND; d++) m_active[d] = m_shadow[d];
          m_pending = 1'b0;
        end else if (commit) begin
          m_pending = 1'b1;
        end
      end
      e_seg = '1;
      e_en  = '0;
      if (m_pos >= 0) begin
        dw = m_pos % DWELL;
        sl = (m_pos / DWELL) % SLOTS;
        dg = (m_pos / (DWELL * SLOTS)) % ND;
`ifdef SIXTEEN_SEGMENT_PWM_EN
        pwm_ok = (dw - BLANK) < (int'(brightness) * (DWELL - BLANK)) / 16;
`else
        pwm_ok = 1'b1;
`endif
        if (dw >= BLANK && !m_active[dg].blank && pwm_ok) begin
          e_en = 2'(1 << dg);
          pat  = exp_font(m_active[dg].glyph);
          if (sl == 16) e_seg[0] = ~m_active[dg].dp;
          else          e_seg[16 - sl] = pat[15 - sl];
        end
      end
      checks += 5;
      if (segment_n !== e_seg) begin
        errors++;
        $display("FAIL cyc_segment_n pos=%0d got=%h exp=%h", m_pos, segment_n, e_seg);
      end
      if (digit_en !== e_en) begin
        errors++;
        $display("FAIL cyc_digit_en pos=%0d got=%b exp=%b", m_pos, digit_en, e_en);
      end
      if (frame_start !== e_fs) begin
        errors++;
        $display("FAIL cyc_frame_start pos=%0d got=%b exp=%b", m_pos, frame_start, e_fs);
      end
      if (commit_pending !== m_pending) begin
        errors++;
        $display("FAIL cyc_commit_pending pos=%0d got=%b exp=%b", m_pos, commit_pending, m_pending);
      end
      if (wr_ready !== !m_pending) begin
        errors++;
        $display("FAIL cyc_wr_ready pos=%0d got=%b exp=%b", m_pos, wr_ready, !m_pending);
      end
    end
  endtask

  // Advance until the scan reaches a given position within the frame.
  task automatic wait_frame_pos(input int target, input int budget);
    int n = 0;
    while (!(m_pos >= 0 && (m_pos % FRAME) == target) && n < budget) begin
      advance(1);
      n++;
    end
    if (!(m_pos >= 0 && (m_pos % FRAME) == target)) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_pos target=%0d got_pos=%0d", target, m_pos);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    advance(3);
    checks += 5;
    if (segment_n !== 17'h1FFFF) begin errors++; $display("FAIL reset_segment_n got=%h exp=1ffff", segment_n); end
    if (digit_en !== 2'b00)      begin errors++; $display("FAIL reset_digit_en got=%b exp=00", digit_en); end
    if (wr_ready !== 1'b1)       begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_commit_pending got=%b exp=0", commit_pending); end
    if (frame_start !== 1'b0)    begin errors++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    reset = 1'b0;
    advance(2);
  endtask

  task automatic test_blank_scan();
    int fs_count  = 0;
    int lit_count = 0;
    enable = 1'b1;
    advance(1);
    for (int k = 0; k < 280; k++) begin
      advance(1);
      if (frame_start) fs_count++;
      if (digit_en != 2'b00 || segment_n != 17'h1FFFF) lit_count++;
    end
    checks += 2;
    if (fs_count != 2)  begin errors++; $display("FAIL blank_frame_starts got=%0d exp=2", fs_count); end
    if (lit_count != 0) begin errors++; $display("FAIL blank_lit_cycles got=%0d exp=0", lit_count); end
  endtask

  task automatic test_write_commit();
    int one_low = 0;
    // Same-cycle write and commit: the write must be part of the swap.
    wr_valid = 1'b1; wr_addr = 1'b0; wr_char = 4'h8; wr_dp = 1'b1; wr_blank = 1'b0;
    commit = 1'b1;
    advance(1);
    wr_valid = 1'b0; commit = 1'b0;
    checks += 2;
    if (commit_pending !== 1'b1) begin errors++; $display("FAIL commit_sets_pending got=%b exp=1", commit_pending); end
    if (wr_ready !== 1'b0)       begin errors++; $display("FAIL commit_drops_ready got=%b exp=0", wr_ready); end
    wait_frame_pos(0, 400);
    checks += 3;
    if (frame_start !== 1'b1)    begin errors++; $display("FAIL swap_frame_start got=%b exp=1", frame_start); end
    if (commit_pending !== 1'b0) begin errors++; $display("FAIL swap_clears_pending got=%b exp=0", commit_pending); end
    if (wr_ready !== 1'b1)       begin errors++; $display("FAIL swap_ready_back got=%b exp=1", wr_ready); end
    for (int k = 1; k < 136; k++) begin
      advance(1);
      if (k < 48 && digit_en == 2'b01 && $countones(~segment_n) == 1) one_low++;
      if (k == 2) begin
        checks++;
        if (segment_n !== 17'h0FFFF || digit_en !== 2'b01) begin
          errors++; $display("FAIL d0_slot_a got=%h/%b exp=0ffff/01", segment_n, digit_en);
        end
      end
      if (k == 66) begin
        checks++;
        if (segment_n !== 17'h1FFFF || digit_en !== 2'b01) begin
          errors++; $display("FAIL d0_slot_k_off got=%h/%b exp=1ffff/01", segment_n, digit_en);
        end
      end
      if (k == 130) begin
        checks++;
        if (segment_n !== 17'h1FFFE || digit_en !== 2'b01) begin
          errors++; $display("FAIL d0_slot_dp got=%h/%b exp=1fffe/01", segment_n, digit_en);
        end
      end
    end
    checks++;
    if (one_low != 6 * LIT_PER_SLOT) begin
      errors++; $display("FAIL d0_a_to_f_lit got=%0d exp=%0d", one_low, 6 * LIT_PER_SLOT);
    end
  endtask

  task automatic test_commit_lockout();
    wr_valid = 1'b1; wr_addr = 1'b1; wr_char = 4'h1; wr_dp = 1'b0; wr_blank = 1'b0;
    advance(1);
    wr_valid = 1'b0; commit = 1'b1;
    advance(1);
    commit = 1'b0;
    // Second write while the swap is pending must be refused.
    wr_valid = 1'b1; wr_char = 4'hF;
    advance(5);
    commit = 1'b1;  // repeated commit while pending
    advance(1);
    commit = 1'b0;
    advance(4);
    checks += 2;
    if (wr_ready !== 1'b0)       begin errors++; $display("FAIL lockout_ready got=%b exp=0", wr_ready); end
    if (commit_pending !== 1'b1) begin errors++; $display("FAIL lockout_pending got=%b exp=1", commit_pending); end
    wr_valid = 1'b0;
    wait_frame_pos(0, 400);
    checks++;
    if (commit_pending !== 1'b0) begin errors++; $display("FAIL lockout_swap_pending got=%b exp=0", commit_pending); end
    wait_frame_pos(138, 200);
    checks++;
    if (segment_n !== 17'h1FFFF || digit_en !== 2'b10) begin
      errors++; $display("FAIL d1_slot_a got=%h/%b exp=1ffff/10", segment_n, digit_en);
    end
    wait_frame_pos(154, 200);
    checks++;
    if (segment_n !== 17'h1BFFF || digit_en !== 2'b10) begin
      errors++; $display("FAIL d1_slot_c got=%h/%b exp=1bfff/10", segment_n, digit_en);
    end
  endtask

  task automatic test_enable_hold();
    advance(1);  // digit 1 slot c, mid drive phase
    enable = 1'b0;
    advance(1);
    checks++;
    if (segment_n !== 17'h1FFFF || digit_en !== 2'b00) begin
      errors++; $display("FAIL hold_off got=%h/%b exp=1ffff/00", segment_n, digit_en);
    end
    wr_valid = 1'b1; wr_addr = 1'b1; wr_char = 4'h2; commit = 1'b1;
    advance(1);
    wr_valid = 1'b0; commit = 1'b0;
    advance(3);
    checks++;
    if (commit_pending !== 1'b1) begin errors++; $display("FAIL hold_pending got=%b exp=1", commit_pending); end
    enable = 1'b1;
    advance(1);
    checks++;
    if (frame_start !== 1'b0 || digit_en !== 2'b00) begin
      errors++; $display("FAIL hold_exit_entry got=%b/%b exp=0/00", frame_start, digit_en);
    end
    advance(1);
    checks += 2;
    if (frame_start !== 1'b1)    begin errors++; $display("FAIL hold_exit_frame_start got=%b exp=1", frame_start); end
    if (commit_pending !== 1'b0) begin errors++; $display("FAIL hold_exit_swap got=%b exp=0", commit_pending); end
    advance(1);
    checks++;
    if (digit_en !== 2'b00) begin errors++; $display("FAIL hold_exit_blank2 got=%b exp=00", digit_en); end
    advance(1);
    checks++;
    if (segment_n !== 17'h0FFFF || digit_en !== 2'b01) begin
      errors++; $display("FAIL hold_exit_slot_a got=%h/%b exp=0ffff/01", segment_n, digit_en);
    end
    wait_frame_pos(138, 200);
    checks++;
    if (segment_n !== 17'h0FFFF || digit_en !== 2'b10) begin
      errors++; $display("FAIL d1_glyph2_slot_a got=%h/%b exp=0ffff/10", segment_n, digit_en);
    end
  endtask

  task automatic test_reset_mid_drive();
    int lit_count = 0;
    commit = 1'b1;
    advance(1);
    commit = 1'b0;
    wait_frame_pos(21, 400);  // digit 0 slot c, drive phase
    checks++;
    if (digit_en !== 2'b01) begin errors++; $display("FAIL pre_reset_lit got=%b exp=01", digit_en); end
    reset = 1'b1;
    advance(1);
    reset = 1'b0;
    checks += 3;
    if (segment_n !== 17'h1FFFF || digit_en !== 2'b00) begin
      errors++; $display("FAIL midreset_off got=%h/%b exp=1ffff/00", segment_n, digit_en);
    end
    if (commit_pending !== 1'b0) begin errors++; $display("FAIL midreset_pending got=%b exp=0", commit_pending); end
    if (wr_ready !== 1'b1)       begin errors++; $display("FAIL midreset_ready got=%b exp=1", wr_ready); end
    for (int k = 0; k < FRAME + 2; k++) begin
      advance(1);
      if (digit_en != 2'b00) lit_count++;
    end
    checks++;
    if (lit_count != 0) begin errors++; $display("FAIL midreset_buffers_blank got=%0d exp=0", lit_count); end
  endtask

`ifdef SIXTEEN_SEGMENT_PWM_EN
  task automatic test_pwm();
    int lit_count = 0;
    brightness = 4'd8;
    wr_valid = 1'b1; wr_addr = 1'b0; wr_char = 4'h8; wr_dp = 1'b0; wr_blank = 1'b0; commit = 1'b1;
    advance(1);
    wr_valid = 1'b0; commit = 1'b0;
    wait_frame_pos(0, 400);
    for (int k = 1; k < 8; k++) begin
      advance(1);
      if (digit_en != 2'b00) lit_count++;
    end
    checks++;
    if (lit_count != 3) begin errors++; $display("FAIL pwm_b8_lit got=%0d exp=3", lit_count); end
    brightness = 4'd0;
    lit_count = 0;
    for (int k = 0; k < FRAME; k++) begin
      advance(1);
      if (digit_en != 2'b00) lit_count++;
    end
    checks++;
    if (lit_count != 0) begin errors++; $display("FAIL pwm_b0_lit got=%0d exp=0", lit_count); end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 1'b0;
    wr_char  = 4'h0;
    wr_dp    = 1'b0;
    wr_blank = 1'b0;
    commit   = 1'b0;
`ifdef SIXTEEN_SEGMENT_PWM_EN
    brightness = 4'd15;
`endif
    model_reset();

    test_reset();
    test_blank_scan();
    test_write_commit();
    test_commit_lockout();
    test_enable_hold();
    test_reset_mid_drive();
`ifdef SIXTEEN_SEGMENT_PWM_EN
    test_pwm();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
